clk_period_monitor: RTL

//  Receiving-end checker for the divided clock produced by the clock divider
//  (divide-by-6 from clk_in: output toggles every 3 clk_in cycles).

---
 rtl/clk_period_monitor.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: checks the divided clock at the receiving end.
// mon_in is synchronised into clk_in and the period between rising edges is
// measured. Lock is declared after LOCK_N consecutive in-tolerance periods.
// After lock, a bad period or a stall raises a sticky fault that only
// clr_fault removes.
module clk_period_monitor #(
    parameter int CNT_W   = 8,
    parameter int EXPECT  = 6,
    parameter int TOL     = 0,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             mon_in,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
);

    localparam int MC_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W:0]   EXP_X  = (CNT_W+1)'(EXPECT);
    localparam logic [CNT_W:0]   TOL_X  = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TOUT_C = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LAST_M = MC_W'(LOCK_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEASURE,
        ST_LOCKED,
        ST_FAULT
    } state_t;

    state_t           r_state;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [MC_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_locked;
    logic             r_fault;

    logic             w_rise;
    logic             w_stall;
    logic             w_match;
    logic [CNT_W:0]   w_cnt_x;
    logic [CNT_W:0]   w_diff;

    // Three-flop chain: two flops for metastability, the third for edge detect.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= mon_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    // Period counter: restarts at 1 on each rise, otherwise counts up and sticks at all-ones.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Absolute deviation is computed one bit wider so neither subtraction can wrap.
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_diff  = (w_cnt_x >= EXP_X) ? (w_cnt_x - EXP_X) : (EXP_X - w_cnt_x);
    assign w_match = (w_diff <= TOL_X);
    assign w_stall = (r_cnt == TOUT_C) & ~w_rise;

    // Lock/fault state machine; every output is registered here so all of them move on one edge.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_match_cnt    <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The interval that ends at the first rise is incomplete, so nothing is reported.
                    if (w_rise) begin
                        r_state     <= ST_MEASURE;
                        r_match_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        r_period       <= r_cnt;
                        r_period_valid <= 1'b1;
                        if (w_match) begin
                            if (r_match_cnt == LAST_M) begin
                                r_state     <= ST_LOCKED;
                                r_locked    <= 1'b1;
                                r_match_cnt <= '0;
                            end else begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                            end
                        end else begin
                            r_match_cnt <= '0;
                        end
                    end else if (w_stall) begin
                        // A stall before lock is not an error; it restarts acquisition.
                        r_state     <= ST_IDLE;
                        r_match_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_rise) begin
                        r_period       <= r_cnt;
                        r_period_valid <= 1'b1;
                        if (!w_match) begin
                            r_state  <= ST_FAULT;
                            r_locked <= 1'b0;
                            r_fault  <= 1'b1;
                        end
                    end else if (w_stall) begin
                        r_state  <= ST_FAULT;
                        r_locked <= 1'b0;
                        r_fault  <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    // Clearing wins over a coincident rise; that rise is dropped.
                    if (clr_fault) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                    end else if (w_rise) begin
                        r_period       <= r_cnt;
                        r_period_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign fault        = r_fault;

endmodule
